systolic_array_2x2: RTL

Output-stationary 2x2 systolic matrix-multiply array, directly downstream of the feeder. It consumes the skewed operand streams `a_data0/1` (weight rows, flowing right) and `b_data0/1` (input columns, flowing down). It accumulates C = A x B in four processing elements and presents the 16-bit signed accumulators `c00..c11` back to the feeder for saturation and readout. One `processing_element` submodule is instantiated four times.

---
 rtl/systolic_array_2x2.sv | 139 +++++++++++++
 1 files changed

// File: rtl/systolic_array_2x2.sv
// ----------------------------------------------------------------------------
// systolic_array_2x2
//
// Output-stationary 2x2 systolic matrix-multiply array. Row operands enter on
// the left and move right one PE per cycle; column operands enter on the top
// and move down one PE per cycle. Each PE accumulates the products of the
// operand pair passing through it, so with the skewed feed described below
// PE(i,j) ends up holding C[i][j] of C = A x B.
//
// Operand skew (T0 = first data cycle after clear drops):
//   T0: a0=A00, b0=B00
//   T1: a0=A01, a1=A10, b0=B10, b1=B01
//   T2: a1=A11, b1=B11
//   all other slots zero. c00 is final after edge T1, c01/c10 after T2 and
//   c11 after T3.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   clear            synchronous active-high clear, identical in effect to rst
//   a_data0/a_data1  signed row operand streams into PE(0,0) / PE(1,0)
//   b_data0/b_data1  signed column operand streams into PE(0,0) / PE(0,1)
//   c00..c11         signed accumulators, straight from the PE registers
//
// Accumulation wraps modulo 2^ACC_W; saturation is done downstream.
// ----------------------------------------------------------------------------

// One processing element: multiply-accumulate plus one-cycle forwarding of
// both operands to the right and downward neighbours.
//   a_in/b_in  operands arriving this cycle
//   a_q/b_q    registered copies forwarded to the neighbours
//   acc        running sum of sign-extended products
module processing_element #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_q,
    output logic signed [DATA_W-1:0] b_q,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    // Both operands signed, so the full-width product is a signed multiply;
    // the signed-to-signed assignment then sign-extends to ACC_W.
    assign prod     = a_in * b_in;
    assign prod_ext = prod;

    always_ff @(posedge clk) begin
        // rst and clear are interchangeable here and override accumulation;
        // operands seen on a clearing edge are dropped, not forwarded.
        if (rst || clear) begin
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            acc <= acc + prod_ext;
            a_q <= a_in;
            b_q <= b_in;
        end
    end

endmodule

module systolic_array_2x2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] a_data0,
    input  logic signed [DATA_W-1:0] a_data1,
    input  logic signed [DATA_W-1:0] b_data0,
    input  logic signed [DATA_W-1:0] b_data1,
    output logic signed [ACC_W-1:0]  c00,
    output logic signed [ACC_W-1:0]  c01,
    output logic signed [ACC_W-1:0]  c10,
    output logic signed [ACC_W-1:0]  c11
);

    // Forwarding links between PEs. The edge PEs' outgoing operands have no
    // consumer; they are kept as named sinks so every PE stays identical.
    logic signed [DATA_W-1:0] a_q00, b_q00;
    logic signed [DATA_W-1:0] b_q01, a_q10;
    logic signed [DATA_W-1:0] a_q01_unused, b_q10_unused;
    logic signed [DATA_W-1:0] a_q11_unused, b_q11_unused;

    processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe00 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a_in  (a_data0),
        .b_in  (b_data0),
        .a_q   (a_q00),
        .b_q   (b_q00),
        .acc   (c00)
    );

    processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe01 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a_in  (a_q00),
        .b_in  (b_data1),
        .a_q   (a_q01_unused),
        .b_q   (b_q01),
        .acc   (c01)
    );

    processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe10 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a_in  (a_data1),
        .b_in  (b_q00),
        .a_q   (a_q10),
        .b_q   (b_q10_unused),
        .acc   (c10)
    );

    processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe11 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a_in  (a_q10),
        .b_in  (b_q01),
        .a_q   (a_q11_unused),
        .b_q   (b_q11_unused),
        .acc   (c11)
    );

endmodule
